// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between ALU and load writeback using round-robin
// arbitration, and tracks outstanding destination writes so issue can stall on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_wb_valid,
  output logic                a_wb_ready,
  input  logic [ADDR_W-1:0]   a_wb_rd,
  input  logic [DATA_W-1:0]   a_wb_data,
  input  logic                m_wb_valid,
  output logic                m_wb_ready,
  input  logic [ADDR_W-1:0]   m_wb_rd,
  input  logic [DATA_W-1:0]   m_wb_data,
  input  logic                rsv_valid,
  input  logic [ADDR_W-1:0]   rsv_rd,
  output logic                rsv_ready,
  input  logic [ADDR_W-1:0]   rs1,
  input  logic [ADDR_W-1:0]   rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [NUM_REGS-1:0] pending,
  output logic                rf_reg_write,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data
);

  logic                last_grant_m;
  logic                grant_a;
  logic                grant_m;
  logic                wr_vld_p0;
  logic [ADDR_W-1:0]   wr_rd_p0;
  logic [DATA_W-1:0]   wr_data_p0;
  logic                wr_vld_p1;
  logic [ADDR_W-1:0]   wr_rd_p1;
  logic [DATA_W-1:0]   wr_data_p1;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                rsv_fire;

  // Stage p0: arbitration and write-port request selection
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (!rst) begin
      if (a_wb_valid && m_wb_valid) begin
        grant_a = last_grant_m;
        grant_m = !last_grant_m;
      end else begin
        grant_a = a_wb_valid;
        grant_m = m_wb_valid;
      end
    end
  end

  assign a_wb_ready = grant_a;
  assign m_wb_ready = grant_m;
  assign wr_rd_p0   = grant_a ? a_wb_rd : m_wb_rd;
  assign wr_data_p0 = grant_a ? a_wb_data : m_wb_data;
  // x0 writes are consumed by the handshake but never reach the register file
  assign wr_vld_p0  = (grant_a || grant_m) && (wr_rd_p0 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_m <= 1'b1;
    end else if (grant_a) begin
      last_grant_m <= 1'b0;
    end else if (grant_m) begin
      last_grant_m <= 1'b1;
    end
  end

  // Stage p1: registered register-file write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_vld_p1  <= 1'b0;
      wr_rd_p1   <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= wr_vld_p0;
      if (wr_vld_p0) begin
        wr_rd_p1   <= wr_rd_p0;
        wr_data_p1 <= wr_data_p0;
      end
    end
  end

  assign rf_reg_write  = wr_vld_p1;
  assign rf_write_reg  = wr_rd_p1;
  assign rf_write_data = wr_data_p1;

  // Scoreboard: set on reservation, clear on the edge the register file commits
  assign rsv_ready = !rst && (!pending_q[rsv_rd] || (rsv_rd == '0));
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_rd != '0);

  always_comb begin
    pending_nxt = pending_q;
    if (wr_vld_p1) begin
      pending_nxt[wr_rd_p1] = 1'b0;
    end
    if (rsv_fire) begin
      pending_nxt[rsv_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_nxt;
    end
  end

  assign pending  = pending_q;
  assign rs1_busy = pending_q[rs1] && (rs1 != '0);
  assign rs2_busy = pending_q[rs2] && (rs2 != '0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench for regfile_wb_scheduler: a bench-side arbitration model predicts grants
// and queues expected register-file writes, which a monitor pops as writes appear.
module tb_regfile_wb_scheduler;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                a_wb_valid, a_wb_ready;
  logic [ADDR_W-1:0]   a_wb_rd;
  logic [DATA_W-1:0]   a_wb_data;
  logic                m_wb_valid, m_wb_ready;
  logic [ADDR_W-1:0]   m_wb_rd;
  logic [DATA_W-1:0]   m_wb_data;
  logic                rsv_valid, rsv_ready;
  logic [ADDR_W-1:0]   rsv_rd;
  logic [ADDR_W-1:0]   rs1, rs2;
  logic                rs1_busy, rs2_busy;
  logic [NUM_REGS-1:0] pending;
  logic                rf_reg_write;
  logic [ADDR_W-1:0]   rf_write_reg;
  logic [DATA_W-1:0]   rf_write_data;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   tests_run = 0;
  int   fails = 0;
  logic exp_last_m;
  logic ga, gm;

  regfile_wb_scheduler #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .a_wb_valid(a_wb_valid), .a_wb_ready(a_wb_ready), .a_wb_rd(a_wb_rd), .a_wb_data(a_wb_data),
    .m_wb_valid(m_wb_valid), .m_wb_ready(m_wb_ready), .m_wb_rd(m_wb_rd), .m_wb_data(m_wb_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pending(pending),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
  );

  always #5 clk = ~clk;

  // Reference arbiter: predicts grants from the driven requests and queues the expected write
  task automatic model_grant(output logic g_a, output logic g_m);
    g_a = 1'b0;
    g_m = 1'b0;
    if (a_wb_valid && m_wb_valid) begin
      g_a = exp_last_m;
      g_m = !exp_last_m;
    end else begin
      g_a = a_wb_valid;
      g_m = m_wb_valid;
    end
    if (g_a) begin
      exp_last_m = 1'b0;
      if (a_wb_rd != '0) exp_q.push_back({a_wb_rd, a_wb_data});
    end else if (g_m) begin
      exp_last_m = 1'b1;
      if (m_wb_rd != '0) exp_q.push_back({m_wb_rd, m_wb_data});
    end
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && rf_reg_write === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL wb_unexpected: got write reg=%0d data=%h, required no write", rf_write_reg, rf_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_write_reg !== mon_e.rd || rf_write_data !== mon_e.data) begin
          fails++;
          $display("FAIL wb_order: got reg=%0d data=%h, required reg=%0d data=%h",
                   rf_write_reg, rf_write_data, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_last_m = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    a_wb_valid = 1'b1; m_wb_valid = 1'b1; rsv_valid = 1'b1; rsv_rd = 5'd3;
    #1;
    tests_run++;
    if (pending !== 32'h0 || rf_reg_write !== 1'b0 || rf_write_reg !== 5'd0 || rf_write_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: got pending=%h we=%b reg=%0d data=%h, required all zero",
               pending, rf_reg_write, rf_write_reg, rf_write_data);
    end
    tests_run++;
    if ({a_wb_ready, m_wb_ready, rsv_ready} !== 3'b000) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 000", {a_wb_ready, m_wb_ready, rsv_ready});
    end
    a_wb_valid = 1'b0; m_wb_valid = 1'b0; rsv_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_a_only();
    @(negedge clk);
    a_wb_valid = 1'b1; a_wb_rd = 5'd5; a_wb_data = 32'hDEADBEEF;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (a_wb_ready !== ga || m_wb_ready !== gm) begin
      fails++;
      $display("FAIL a_only_ready: got a=%b m=%b, required a=%b m=%b", a_wb_ready, m_wb_ready, ga, gm);
    end
    @(negedge clk);
    a_wb_valid = 1'b0;
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd5 || rf_write_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL a_only_write: got we=%b reg=%0d data=%h, required 1/5/deadbeef",
               rf_reg_write, rf_write_reg, rf_write_data);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b0) begin
      fails++;
      $display("FAIL a_only_single: got we=%b, required 0", rf_reg_write);
    end
  endtask

  task automatic test_round_robin();
    int a_seq = 0;
    int m_seq = 0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_wb_valid = 1'b1; a_wb_rd = 5'd1; a_wb_data = 32'hA000_0000 + a_seq;
      m_wb_valid = 1'b1; m_wb_rd = 5'd2; m_wb_data = 32'hB000_0000 + m_seq;
      #1;
      model_grant(ga, gm);
      tests_run++;
      if (a_wb_ready !== ga || m_wb_ready !== gm) begin
        fails++;
        $display("FAIL rr_grant[%0d]: got a=%b m=%b, required a=%b m=%b", c, a_wb_ready, m_wb_ready, ga, gm);
      end
      if (c > 0) begin
        tests_run++;
        if (rf_reg_write !== 1'b1) begin
          fails++;
          $display("FAIL rr_we[%0d]: got %b, required 1", c, rf_reg_write);
        end
      end
      if (ga) a_seq++;
      if (gm) m_seq++;
    end
    @(negedge clk);
    a_wb_valid = 1'b0; m_wb_valid = 1'b0;
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b1) begin
      fails++;
      $display("FAIL rr_we_last: got %b, required 1", rf_reg_write);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rr_drain: got we=%b outstanding=%0d, required 0/0", rf_reg_write, exp_q.size());
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    #1;
    tests_run++;
    if (rsv_ready !== 1'b1) begin
      fails++;
      $display("FAIL sb_rsv: got %b, required 1", rsv_ready);
    end
    @(negedge clk);
    rsv_valid = 1'b0; rs1 = 5'd7;
    #1;
    tests_run++;
    if (rs1_busy !== 1'b1 || pending !== 32'h0000_0080) begin
      fails++;
      $display("FAIL sb_busy: got busy=%b pending=%h, required 1/00000080", rs1_busy, pending);
    end
    @(negedge clk);
    m_wb_valid = 1'b1; m_wb_rd = 5'd7; m_wb_data = 32'h0707_0707;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (m_wb_ready !== gm || rs1_busy !== 1'b1) begin
      fails++;
      $display("FAIL sb_grant: got ready=%b busy=%b, required %b/1", m_wb_ready, rs1_busy, gm);
    end
    @(negedge clk);
    m_wb_valid = 1'b0;
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b1 || rs1_busy !== 1'b1) begin
      fails++;
      $display("FAIL sb_commit_window: got we=%b busy=%b, required 1/1", rf_reg_write, rs1_busy);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rs1_busy !== 1'b0 || pending !== 32'h0) begin
      fails++;
      $display("FAIL sb_clear: got busy=%b pending=%h, required 0/00000000", rs1_busy, pending);
    end
    rs1 = 5'd0;
  endtask

  task automatic test_waw();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    #1;
    tests_run++;
    if (rsv_ready !== 1'b1) begin
      fails++;
      $display("FAIL waw_first: got %b, required 1", rsv_ready);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rsv_ready !== 1'b0) begin
      fails++;
      $display("FAIL waw_hold: got %b, required 0", rsv_ready);
    end
    @(negedge clk);
    a_wb_valid = 1'b1; a_wb_rd = 5'd7; a_wb_data = 32'h0000_7777;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (a_wb_ready !== ga || rsv_ready !== 1'b0) begin
      fails++;
      $display("FAIL waw_grant: got a=%b rsv=%b, required %b/0", a_wb_ready, rsv_ready, ga);
    end
    @(negedge clk);
    a_wb_valid = 1'b0;
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b1 || rsv_ready !== 1'b0) begin
      fails++;
      $display("FAIL waw_commit_cycle: got we=%b rsv=%b, required 1/0", rf_reg_write, rsv_ready);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rsv_ready !== 1'b1 || pending !== 32'h0) begin
      fails++;
      $display("FAIL waw_release: got rsv=%b pending=%h, required 1/00000000", rsv_ready, pending);
    end
    @(negedge clk);
    rsv_rd = 5'd0;
    #1;
    tests_run++;
    if (rsv_ready !== 1'b1 || pending !== 32'h0000_0080) begin
      fails++;
      $display("FAIL waw_x0_rsv: got rsv=%b pending=%h, required 1/00000080", rsv_ready, pending);
    end
    @(negedge clk);
    rsv_valid = 1'b0; rs2 = 5'd0;
    #1;
    tests_run++;
    if (pending !== 32'h0000_0080 || rs2_busy !== 1'b0) begin
      fails++;
      $display("FAIL waw_x0_busy: got pending=%h busy=%b, required 00000080/0", pending, rs2_busy);
    end
    @(negedge clk);
    rs2 = 5'd7; m_wb_valid = 1'b1; m_wb_rd = 5'd7; m_wb_data = 32'h7070_7070;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (rs2_busy !== 1'b1 || m_wb_ready !== gm) begin
      fails++;
      $display("FAIL waw_rs2: got busy=%b m=%b, required 1/%b", rs2_busy, m_wb_ready, gm);
    end
    @(negedge clk);
    m_wb_valid = 1'b0; rsv_valid = 1'b1; rsv_rd = 5'd3;
    #1;
    tests_run++;
    if (rsv_ready !== 1'b1 || rf_reg_write !== 1'b1) begin
      fails++;
      $display("FAIL set_clear_rsv: got rsv=%b we=%b, required 1/1", rsv_ready, rf_reg_write);
    end
    @(negedge clk);
    rsv_valid = 1'b0; rs2 = 5'd0;
    #1;
    tests_run++;
    if (pending !== 32'h0000_0008) begin
      fails++;
      $display("FAIL set_clear_same_edge: got pending=%h, required 00000008", pending);
    end
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    a_wb_valid = 1'b1; a_wb_rd = 5'd0; a_wb_data = 32'h0000_1234;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (a_wb_ready !== ga) begin
      fails++;
      $display("FAIL x0_ready: got %b, required %b", a_wb_ready, ga);
    end
    @(negedge clk);
    a_wb_rd = 5'd9; a_wb_data = 32'h0000_0099;
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b0) begin
      fails++;
      $display("FAIL x0_no_write: got we=%b, required 0", rf_reg_write);
    end
    model_grant(ga, gm);
    @(negedge clk);
    a_wb_valid = 1'b0;
    @(negedge clk);
    m_wb_valid = 1'b1; m_wb_rd = 5'd3; m_wb_data = 32'h0303_0303;
    #1;
    tests_run++;
    if (pending !== 32'h0000_0008) begin
      fails++;
      $display("FAIL nonpending_write: got pending=%h, required 00000008", pending);
    end
    model_grant(ga, gm);
    @(negedge clk);
    m_wb_valid = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (pending !== 32'h0) begin
      fails++;
      $display("FAIL clear_r3: got pending=%h, required 00000000", pending);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rsv_valid = 1'b1; rsv_rd = 5'd4;
    @(negedge clk);
    rsv_rd = 5'd7;
    @(negedge clk);
    rsv_valid = 1'b0; a_wb_valid = 1'b1; a_wb_rd = 5'd4; a_wb_data = 32'h4444_4444;
    #1;
    model_grant(ga, gm);
    @(negedge clk);
    a_wb_valid = 1'b0;
    #1;
    tests_run++;
    if (pending !== 32'h0000_0090 || rf_reg_write !== 1'b1) begin
      fails++;
      $display("FAIL rmid_before: got pending=%h we=%b, required 00000090/1", pending, rf_reg_write);
    end
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_last_m = 1'b1;
    a_wb_valid = 1'b1; a_wb_rd = 5'd10; a_wb_data = 32'h0A0A_0A0A;
    m_wb_valid = 1'b1; m_wb_rd = 5'd11; m_wb_data = 32'h0B0B_0B0B;
    rsv_valid = 1'b1; rsv_rd = 5'd5;
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b0 || pending !== 32'h0 || {a_wb_ready, m_wb_ready, rsv_ready} !== 3'b000) begin
      fails++;
      $display("FAIL rmid_async: got we=%b pending=%h ready=%b, required 0/0/000",
               rf_reg_write, pending, {a_wb_ready, m_wb_ready, rsv_ready});
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (rf_reg_write !== 1'b0 || {a_wb_ready, m_wb_ready, rsv_ready} !== 3'b000) begin
      fails++;
      $display("FAIL rmid_held: got we=%b ready=%b, required 0/000", rf_reg_write, {a_wb_ready, m_wb_ready, rsv_ready});
    end
    @(negedge clk);
    rst = 1'b0; rsv_valid = 1'b0;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (a_wb_ready !== ga || m_wb_ready !== gm) begin
      fails++;
      $display("FAIL rmid_first_conflict: got a=%b m=%b, required a=%b m=%b", a_wb_ready, m_wb_ready, ga, gm);
    end
    @(negedge clk);
    a_wb_valid = 1'b0;
    #1;
    model_grant(ga, gm);
    tests_run++;
    if (m_wb_ready !== gm || rf_reg_write !== 1'b1) begin
      fails++;
      $display("FAIL rmid_second: got m=%b we=%b, required %b/1", m_wb_ready, rf_reg_write, gm);
    end
    @(negedge clk);
    m_wb_valid = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0 || rf_reg_write !== 1'b0) begin
      fails++;
      $display("FAIL final_drain: got outstanding=%0d we=%b, required 0/0", exp_q.size(), rf_reg_write);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_wb_valid = 1'b0; a_wb_rd = '0; a_wb_data = '0;
    m_wb_valid = 1'b0; m_wb_rd = '0; m_wb_data = '0;
    rsv_valid = 1'b0; rsv_rd = '0; rs1 = '0; rs2 = '0;
    exp_last_m = 1'b1;
    test_reset();
    test_a_only();
    test_round_robin();
    test_scoreboard();
    test_waw();
    test_x0_write();
    test_reset_mid();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
